mul_seq_ctrl: RTL and testbench

Control unit for the shift-and-add multiplier datapath. It accepts one operand pair over a valid/ready handshake and sequences the datapath with clear, load and busy strobes for the operand width. It then waits for the datapath's ready flag, captures the double-width product, and presents it downstream over a second valid/ready handshake. It sits directly upstream of the datapath: it drives the datapath's operand and control inputs and consumes its product and ready outputs.

---
 rtl/mul_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a shift-and-add multiplier: one operand pair in, clear/load/busy strobes out, product back.
// Latency: product valid WIDTH+2 cycles after acceptance with dp_ready high on the first WAIT cycle.
// Backpressure: single operation in flight; product held in DONE until out_ready, in_ready low outside IDLE.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     operand handshake, in_a/in_b operands
//   dp_clear/dp_load      one-cycle datapath strobes, dp_busy shift/add enable
//   dp_opa/dp_opb         registered operands to the datapath
//   dp_mul/dp_ready       product and completion flag from the datapath
//   out_valid/out_ready   product handshake, out_prod product, out_err watchdog abort
//
// Optional feature: define MUL_SEQ_CTRL_WATCHDOG_EN to abort a WAIT that exceeds TIMEOUT cycles.
module mul_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 dp_clear,
    output logic                 dp_load,
    output logic                 dp_busy,
    output logic [WIDTH-1:0]     dp_opa,
    output logic [WIDTH-1:0]     dp_opb,
    input  logic [2*WIDTH-1:0]   dp_mul,
    input  logic                 dp_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_err
);

    localparam int CW = $clog2(WIDTH + 1);

    // Reject configurations the counter and watchdog cannot represent.
    if (WIDTH < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("mul_seq_ctrl: WIDTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            handshake;
    logic            wd_expire;

`ifdef MUL_SEQ_CTRL_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wd_cnt;

    // Fires on the TIMEOUT-th consecutive WAIT cycle without dp_ready.
    assign wd_expire = (state == S_WAIT) && !dp_ready && (wd_cnt == TW'(TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = (state == S_IDLE) && in_valid && in_ready;
        handshake = (state == S_DONE) && out_valid && out_ready;
        case (state)
            S_IDLE: if (accept) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_RUN;
            S_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = S_WAIT;
            // dp_ready is only looked at here, so a flag left high from the
            // previous product cannot end LOAD or RUN early.
            S_WAIT: if (dp_ready || wd_expire) state_nxt = S_DONE;
            S_DONE: if (handshake) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop
    // that is already valid in the first cycle of its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b0;
            dp_clear  <= 1'b0;
            dp_load   <= 1'b0;
            dp_busy   <= 1'b0;
            dp_opa    <= '0;
            dp_opb    <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            cnt       <= '0;
        end else begin
            in_ready  <= (state_nxt == S_IDLE);
            dp_clear  <= (state_nxt == S_LOAD);
            dp_load   <= (state_nxt == S_LOAD);
            dp_busy   <= (state_nxt == S_RUN);
            out_valid <= (state_nxt == S_DONE);

            if (accept) begin
                dp_opa <= in_a;
                dp_opb <= in_b;
            end

            if (state == S_LOAD) begin
                cnt <= '0;
            end else if (state == S_RUN) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == S_WAIT) && dp_ready) begin
                out_prod <= dp_mul;
            end else if (wd_expire) begin
                out_prod <= '0;
            end
        end
    end

`ifdef MUL_SEQ_CTRL_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt  <= '0;
            out_err <= 1'b0;
        end else begin
            if ((state == S_RUN) && (state_nxt == S_WAIT)) begin
                wd_cnt <= '0;
            end else if ((state == S_WAIT) && !dp_ready && !wd_expire) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if ((state == S_WAIT) && dp_ready) begin
                out_err <= 1'b0;
            end else if (wd_expire) begin
                out_err <= 1'b1;
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a small shift-and-add datapath stand-in.
// Latency: checks acceptance-to-valid timing, busy length and issue interval cycle by cycle.
// Backpressure: holds out_ready low in DONE and checks the product stays put.
module tb_mul_seq_ctrl;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 dp_clear;
    logic                 dp_load;
    logic                 dp_busy;
    logic [WIDTH-1:0]     dp_opa;
    logic [WIDTH-1:0]     dp_opb;
    logic [2*WIDTH-1:0]   dp_mul;
    logic                 dp_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic                 out_err;

    int n_chk = 0;
    int n_err = 0;

    mul_seq_ctrl #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .dp_clear  (dp_clear),
        .dp_load   (dp_load),
        .dp_busy   (dp_busy),
        .dp_opa    (dp_opa),
        .dp_opb    (dp_opb),
        .dp_mul    (dp_mul),
        .dp_ready  (dp_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: finishes after WIDTH busy cycles and keeps dp_ready
    // sticky; the product reads as DEAD until then so an early capture shows.
    // rdy_mode 0 = model, 1 = forced high, 2 = forced low.
    logic [1:0] rdy_mode;
    logic       mdl_done;
    int         mdl_cnt;

    always @(posedge clk) begin
        if (reset || dp_load) begin
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
        end else if (dp_busy) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == WIDTH - 1) mdl_done <= 1'b1;
        end
    end

    assign dp_ready = (rdy_mode == 2'd1) ? 1'b1 : (rdy_mode == 2'd2) ? 1'b0 : mdl_done;
    assign dp_mul   = mdl_done ? ({8'h00, dp_opa} * {8'h00, dp_opb}) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers one pair at a negedge where in_ready is high, then watches until
    // out_valid. t counts edges after acceptance (t=0 is just after E0).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int t_vld, output int n_load, output int n_busy);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t_vld  = -1;
        n_load = 0;
        n_busy = 0;
        for (int t = 0; t < 60; t++) begin
            if (dp_load) n_load++;
            if (dp_busy) n_busy++;
            if (out_valid) begin
                t_vld = t;
                break;
            end
            @(negedge clk);
        end
    endtask

    int          t_vld, n_load, n_busy;
    logic [7:0]  ea [2];
    logic [7:0]  eb [2];
    int          acc_t [2];
    logic [15:0] prods [2];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rdy_mode  = 2'd0;
        ea[0] = 8'hFF; eb[0] = 8'hFF;
        ea[1] = 8'h01; eb[1] = 8'h02;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_prod", out_prod, 0);
        check("rst_dp_busy", dp_busy, 0);
        check("rst_dp_opa", dp_opa, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Product path: 0x0D * 0x0B = 0x008F
        run_op(8'h0D, 8'h0B, t_vld, n_load, n_busy);
        check("prod_load_pulses", n_load, 1);
        check("prod_busy_cycles", n_busy, 8);
        check("prod_valid_latency", t_vld, 10);
        check("prod_value", out_prod, 16'h008F);
        check("prod_err", out_err, 0);
        check("prod_opa", dp_opa, 8'h0D);
        check("prod_opb", dp_opb, 8'h0B);
        @(negedge clk);
        check("prod_done_one_cycle", out_valid, 0);
        check("prod_in_ready_back", in_ready, 1);

        // Backpressure: 0x0C * 0x0A = 0x0078 held for 20 cycles
        out_ready = 1'b0;
        run_op(8'h0C, 8'h0A, t_vld, n_load, n_busy);
        check("bp_valid_latency", t_vld, 10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_prod", out_prod, 16'h0078);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_once", out_valid, 0);
        check("bp_in_ready_next", in_ready, 1);

        // Stale ready: dp_ready high throughout, 0x05 * 0x03 = 0x000F
        rdy_mode = 2'd1;
        run_op(8'h05, 8'h03, t_vld, n_load, n_busy);
        check("stale_busy_cycles", n_busy, 8);
        check("stale_valid_latency", t_vld, 10);
        check("stale_prod", out_prod, 16'h000F);
        rdy_mode = 2'd0;
        @(negedge clk);

        // Back-to-back with in_valid held: (FF,FF) then (01,02)
        begin
            int   nacc = 0;
            int   nload = 0;
            int   nv = 0;
            logic pv = 1'b0;
            logic pend = 1'b0;
            in_a     = ea[0];
            in_b     = eb[0];
            in_valid = 1'b1;
            for (int t = 0; t < 60; t++) begin
                if (pend) begin
                    pend = 1'b0;
                    if (nacc == 1) begin
                        in_a = ea[1];
                        in_b = eb[1];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (dp_load) begin
                    nload++;
                    if (nacc >= 1 && nacc <= 2) begin
                        check("b2b_opa", dp_opa, ea[nacc-1]);
                        check("b2b_opb", dp_opb, eb[nacc-1]);
                    end
                end
                if (out_valid && !pv) begin
                    if (nv < 2) prods[nv] = out_prod;
                    nv++;
                end
                pv = out_valid;
                if (in_valid && in_ready) begin
                    if (nacc < 2) acc_t[nacc] = t;
                    nacc++;
                    pend = 1'b1;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("b2b_accepts", nacc, 2);
            check("b2b_loads", nload, 2);
            check("b2b_results", nv, 2);
            if (nacc >= 2) check("b2b_interval", acc_t[1] - acc_t[0], 12);
            if (nv >= 2) begin
                check("b2b_prod0", prods[0], 16'hFE01);
                check("b2b_prod1", prods[1], 16'h0002);
            end
        end

        // Reset mid-RUN at RUN cycle 4
        check("mr_idle_before", in_ready, 1);
        in_a     = 8'h03;
        in_b     = 8'h04;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mr_busy_at_run4", dp_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_in_ready", in_ready, 0);
        check("mr_dp_clear", dp_clear, 0);
        check("mr_dp_load", dp_load, 0);
        check("mr_dp_busy", dp_busy, 0);
        check("mr_dp_opa", dp_opa, 0);
        check("mr_dp_opb", dp_opb, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_prod", out_prod, 0);
        check("mr_out_err", out_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_in_ready_after", in_ready, 1);
        check("mr_busy_after", dp_busy, 0);

        // Watchdog: dp_ready never asserted
        rdy_mode = 2'd2;
`ifdef MUL_SEQ_CTRL_WATCHDOG_EN
        run_op(8'h07, 8'h09, t_vld, n_load, n_busy);
        check("wd_valid_latency", t_vld, 25);
        check("wd_out_err", out_err, 1);
        check("wd_out_prod", out_prod, 0);
        @(negedge clk);
        check("wd_released", out_valid, 0);
`else
        begin
            int seen = 0;
            in_a     = 8'h07;
            in_b     = 8'h09;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (out_valid) seen++;
                @(negedge clk);
            end
            check("nowd_no_valid", seen, 0);
            check("nowd_in_ready", in_ready, 0);
            check("nowd_busy", dp_busy, 0);
            check("nowd_err", out_err, 0);
        end
`endif
        rdy_mode = 2'd0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
